seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, handshaked successor of the combinational 12-op ALU.
- Keeps the same 4-bit opcode map and generalises the data width.
- Adds the previously unimplemented MUL, plus MULHU, DIVU and REMU.
- MUL/MULHU use a multi-cycle shift-add unit; DIVU/REMU use a multi-cycle restoring divider.
- Sits between an operand-issue stage and a writeback stage, using valid/ready on both sides.

Parameters:
- WIDTH, 32, datapath width. Legal values: power of two, 8..64.
- SHW, $clog2(WIDTH), derived localparam. Shift-amount width; op2[SHW-1:0] is the shift amount.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  synchronous reset, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_ctrl  in  4  opcode.
- in_op1  in  WIDTH  operand 1.
- in_op2  in  WIDTH  operand 2.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  result.
- out_zero  out  1  out_result == 0.

Behaviour:
- Opcodes (all results are WIDTH bits):
  - 0 SLL, 1 SRL, 2 SRA (signed shift of op1), 3 ADD, 4 SUB (wrap-around).
  - 5 AND, 6 OR, 7 XOR, 8 NOR.
  - 9 SLT: unsigned compare, result 1 or 0.
  - A LUI: op1 << WIDTH/2.
  - B MUL: low WIDTH bits of the unsigned product.
  - C MULHU: high WIDTH bits of the unsigned product.
  - D DIVU: unsigned quotient.
  - E REMU: unsigned remainder.
  - F: result 0.
- Divide by zero: DIVU returns all-ones; REMU returns op1. No exception is raised.
- FSM states: IDLE, MUL, DIV.
  - IDLE: in_ready = !out_valid || out_ready.
  - MUL and DIV: in_ready = 0.
- Single-cycle op accepted in IDLE:
  - Result registered; out_valid = 1 on the next cycle.
  - Latency 1.
  - Back-to-back throughput of 1 per cycle when out_ready is held high.
- Opcode B–E accepted:
  - Operands latched; move to MUL or DIV.
  - Iteration counter loads WIDTH-1 and performs one bit per cycle.
  - On the cycle the counter is 0: load the result, assert out_valid, return to IDLE.
  - Latency WIDTH cycles from accept to out_valid.
  - MUL: 2*WIDTH-bit accumulator, selecting low or high half at the end.
  - DIV: restoring divider with WIDTH+1-bit partial remainder.
- Output hold:
  - While out_valid && !out_ready, out_result and out_zero are stable, and no new request is accepted (in_ready = 0).
  - out_valid clears on a handshake unless a new single-cycle result loads in the same cycle.
- out_zero is registered together with out_result. It is never derived combinationally from input operands.
- Same-cycle output handshake and new accept in IDLE: the new result replaces the old one; no bubble.
- out_ready has no effect while in MUL or DIV.
- Reset, effective at any time including mid-operation:
  - state = IDLE; out_valid = 0; out_result = 0; out_zero = 1.
  - Counter and accumulators cleared; any in-flight op is discarded.
  - in_ready = 1 on the first cycle after reset_n deasserts.
- in_ctrl/in_op1/in_op2 are sampled only on accept; later changes have no effect.

Decomposition:
- Package seq_alu_pkg holds:
  - Opcode constants as an enum typedef alu_op_t (4-bit).
  - State enum typedef alu_state_t.
- Sub-module seq_alu_muldiv (WIDTH parameter):
  - Holds the iterative multiply/divide datapath and counter.
  - Interface: start, op, a, b, done, res.
- The top module holds the single-cycle ops, FSM and output register.

Test Plan:
- WIDTH=32: ADD 0xFFFFFFFF+1, out_ready=1 -> out_valid next cycle; result 0, out_zero=1. SUB 5-7 -> 0xFFFFFFFE.
- SRA 0x80000000 by op2=0x24 (shift amount 4) -> 0xF8000000. SRL same -> 0x08000000. LUI 0x1234 -> 0x12340000.
- MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001 after exactly 32 cycles; MULHU -> 0xFFFFFFFE. in_ready low throughout.
- DIVU 100/7 -> 14; REMU -> 2. DIVU x/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
- Backpressure: out_ready=0 for 5 cycles after an ADD result -> result held stable, in_ready=0. Then out_ready=1 with a new ADD presented -> accepted the same cycle, next result the following cycle.
- Reset asserted 10 cycles into a DIVU -> next cycle: out_valid=0, out_result=0, out_zero=1, in_ready=1. The following SLT 3<5 -> 1. Repeat the ADD and MUL checks with WIDTH=16 (MUL latency 16).

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM state types for the sequential ALU.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_SLL   = 4'h0,
        OP_SRL   = 4'h1,
        OP_SRA   = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_NOR   = 4'h8,
        OP_SLT   = 4'h9,
        OP_LUI   = 4'hA,
        OP_MUL   = 4'hB,
        OP_MULHU = 4'hC,
        OP_DIVU  = 4'hD,
        OP_REMU  = 4'hE,
        OP_ZERO  = 4'hF
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } alu_state_t;

    function automatic logic is_multi_cycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic is_divide(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res
);
    localparam int SHW = $clog2(WIDTH);

    logic               busy_r;
    logic [SHW-1:0]     cnt_r;
    logic               is_div_r;
    logic               sel_hi_r;
    logic [WIDTH-1:0]   opnd_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH:0]     rem_r;
    logic [WIDTH-1:0]   quo_r;

    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [WIDTH:0]     rem_next_s;
    logic [WIDTH-1:0]   quo_next_s;

    // One iteration of both datapaths; a negative trial difference restores the remainder.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        acc_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
        div_shift_s = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        if (div_diff_s[WIDTH]) begin
            rem_next_s = div_shift_s;
            quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
        end else begin
            rem_next_s = div_diff_s;
            quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
        end
    end

    // Result selection taken from the final iteration's next values.
    always_comb begin
        done = busy_r && (cnt_r == {SHW{1'b0}});
        if (is_div_r) begin
            res = sel_hi_r ? rem_next_s[WIDTH-1:0] : quo_next_s;
        end else begin
            res = sel_hi_r ? acc_next_s[2*WIDTH-1:WIDTH] : acc_next_s[WIDTH-1:0];
        end
    end

    // Operand capture on start, then one bit per cycle until the counter expires.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy_r   <= 1'b0;
            cnt_r    <= {SHW{1'b0}};
            is_div_r <= 1'b0;
            sel_hi_r <= 1'b0;
            opnd_r   <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            rem_r    <= {(WIDTH+1){1'b0}};
            quo_r    <= {WIDTH{1'b0}};
        end else if (start) begin
            busy_r   <= 1'b1;
            cnt_r    <= SHW'(WIDTH - 1);
            is_div_r <= is_divide(op);
            sel_hi_r <= (op == OP_MULHU) || (op == OP_REMU);
            opnd_r   <= is_divide(op) ? b : a;
            acc_r    <= {{WIDTH{1'b0}}, b};
            rem_r    <= {(WIDTH+1){1'b0}};
            quo_r    <= a;
        end else if (busy_r) begin
            acc_r <= acc_next_s;
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            cnt_r <= cnt_r - SHW'(1);
            if (cnt_r == {SHW{1'b0}}) begin
                busy_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops registered directly, MUL/DIV ops via the iterative unit.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_ctrl,
    input  logic [WIDTH-1:0] in_op1,
    input  logic [WIDTH-1:0] in_op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero
);
    localparam int SHW = $clog2(WIDTH);

    alu_state_t       state_r;
    logic             accept_s;
    logic             multi_s;
    logic [WIDTH-1:0] alu_s;
    logic             md_done_s;
    logic [WIDTH-1:0] md_res_s;

    assign in_ready = (state_r == ST_IDLE) && (!out_valid || out_ready);
    assign accept_s = in_valid && in_ready;
    assign multi_s  = is_multi_cycle(in_ctrl);

    // Single-cycle operations; SLT is an unsigned compare.
    always_comb begin
        alu_s = {WIDTH{1'b0}};
        case (alu_op_t'(in_ctrl))
            OP_SLL:  alu_s = in_op1 << in_op2[SHW-1:0];
            OP_SRL:  alu_s = in_op1 >> in_op2[SHW-1:0];
            OP_SRA:  alu_s = $unsigned($signed(in_op1) >>> in_op2[SHW-1:0]);
            OP_ADD:  alu_s = in_op1 + in_op2;
            OP_SUB:  alu_s = in_op1 - in_op2;
            OP_AND:  alu_s = in_op1 & in_op2;
            OP_OR:   alu_s = in_op1 | in_op2;
            OP_XOR:  alu_s = in_op1 ^ in_op2;
            OP_NOR:  alu_s = ~(in_op1 | in_op2);
            OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, (in_op1 < in_op2)};
            OP_LUI:  alu_s = in_op1 << (WIDTH / 2);
            default: alu_s = {WIDTH{1'b0}};
        endcase
    end

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (accept_s && multi_s),
        .op      (in_ctrl),
        .a       (in_op1),
        .b       (in_op2),
        .done    (md_done_s),
        .res     (md_res_s)
    );

    // Control FSM and output register; out_zero always travels with out_result.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            out_valid  <= 1'b0;
            out_result <= {WIDTH{1'b0}};
            out_zero   <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && multi_s) begin
                        out_valid <= 1'b0;
                        state_r   <= is_divide(in_ctrl) ? ST_DIV : ST_MUL;
                    end else if (accept_s) begin
                        out_valid  <= 1'b1;
                        out_result <= alu_s;
                        out_zero   <= (alu_s == {WIDTH{1'b0}});
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (md_done_s) begin
                        out_valid  <= 1'b1;
                        out_result <= md_res_s;
                        out_zero   <= (md_res_s == {WIDTH{1'b0}});
                        state_r    <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=32 and WIDTH=16: directed table, corner sequences, random vs model.
module tb_seq_alu;

    typedef struct {
        bit                 sel;
        logic [3:0]         ctrl;
        longint unsigned    a;
        longint unsigned    b;
        longint unsigned    exp;
        int                 wait_c;
    } vec_t;

    logic        clock;
    logic        reset_n;
    logic        in_valid_s;
    logic [3:0]  ctrl_s;
    logic [63:0] op1_s;
    logic [63:0] op2_s;
    logic        out_ready_s;
    bit          sel_s;

    logic        in_ready32, out_valid32, zero32;
    logic [31:0] result32;
    logic        in_ready16, out_valid16, zero16;
    logic [15:0] result16;

    logic        cur_in_ready, cur_out_valid, cur_zero;
    logic [63:0] cur_result;

    int checks;
    int errors;
    vec_t vecs[$];

    seq_alu #(.WIDTH(32)) dut32 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid_s && !sel_s), .in_ready(in_ready32),
        .in_ctrl(ctrl_s), .in_op1(op1_s[31:0]), .in_op2(op2_s[31:0]), .out_valid(out_valid32),
        .out_ready(out_ready_s), .out_result(result32), .out_zero(zero32)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid_s && sel_s), .in_ready(in_ready16),
        .in_ctrl(ctrl_s), .in_op1(op1_s[15:0]), .in_op2(op2_s[15:0]), .out_valid(out_valid16),
        .out_ready(out_ready_s), .out_result(result16), .out_zero(zero16)
    );

    assign cur_in_ready  = sel_s ? in_ready16 : in_ready32;
    assign cur_out_valid = sel_s ? out_valid16 : out_valid32;
    assign cur_zero      = sel_s ? zero16 : zero32;
    assign cur_result    = sel_s ? {48'h0, result16} : {32'h0, result32};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic add_vec(input bit s, input logic [3:0] c, input longint unsigned a,
                           input longint unsigned b, input longint unsigned e, input int w);
        vec_t v;
        v = '{s, c, a, b, e, w};
        vecs.push_back(v);
    endtask

    // Reference: operations evaluated with plain 64-bit arithmetic, then masked to w bits.
    function automatic longint unsigned model(input int w, input logic [3:0] c,
                                              input longint unsigned a_in, input longint unsigned b_in);
        longint unsigned mask, a, b, r;
        longint sa;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        a = a_in & mask;
        b = b_in & mask;
        sh = int'(b & longint'(w - 1));
        if (((a >> (w - 1)) & 64'd1) != 64'd0) sa = a | ~mask;
        else sa = a;
        case (c)
            4'h0: r = a << sh;
            4'h1: r = a >> sh;
            4'h2: r = $unsigned(sa >>> sh);
            4'h3: r = a + b;
            4'h4: r = a - b;
            4'h5: r = a & b;
            4'h6: r = a | b;
            4'h7: r = a ^ b;
            4'h8: r = ~(a | b);
            4'h9: r = (a < b) ? 64'd1 : 64'd0;
            4'hA: r = a << (w / 2);
            4'hB: r = a * b;
            4'hC: r = (a * b) >> w;
            4'hD: r = (b == 64'd0) ? mask : a / b;
            4'hE: r = (b == 64'd0) ? a : a % b;
            default: r = 64'd0;
        endcase
        return r & mask;
    endfunction

    // Issue one request with out_ready high, return result, zero flag and busy-cycle count.
    task automatic run_op(input bit s, input logic [3:0] c, input longint unsigned a, input longint unsigned b,
                          output longint unsigned res, output bit z, output int lat, output bit rdy_seen);
        int n;
        sel_s = s; ctrl_s = c; op1_s = a; op2_s = b;
        in_valid_s = 1'b1; out_ready_s = 1'b1; rdy_seen = 1'b0; n = 0;
        #1;
        while (!cur_in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stayed low for %0d cycles", n);
        end
        tick();
        in_valid_s = 1'b0;
        op1_s = {$urandom, $urandom};
        op2_s = {$urandom, $urandom};
        ctrl_s = 4'($urandom);
        lat = 0;
        while (!cur_out_valid && lat < 200) begin
            if (cur_in_ready) rdy_seen = 1'b1;
            out_ready_s = 1'($urandom);
            tick();
            lat++;
        end
        out_ready_s = 1'b1;
        if (lat >= 200) begin
            checks++; errors++;
            $display("FAIL result_timeout: out_valid never rose within %0d cycles", lat);
        end
        res = cur_result;
        z = cur_zero;
    endtask

    initial begin
        longint unsigned r;
        bit z, rs;
        int lt, seen;
        checks = 0; errors = 0;
        sel_s = 1'b0; in_valid_s = 1'b0; ctrl_s = 4'h0; op1_s = 64'h0; op2_s = 64'h0; out_ready_s = 1'b0;
        reset_n = 1'b0;
        repeat (2) tick();
        for (int s = 0; s < 2; s++) begin
            sel_s = 1'(s);
            #1;
            check("rst_valid", {63'h0, cur_out_valid}, 64'h0);
            check("rst_result", cur_result, 64'h0);
            check("rst_zero", {63'h0, cur_zero}, 64'h1);
            check("rst_ready", {63'h0, cur_in_ready}, 64'h1);
        end
        reset_n = 1'b1;
        tick();

        add_vec(0, 4'h3, 64'hFFFFFFFF, 64'h1, 64'h0, 0);
        add_vec(0, 4'h4, 64'h5, 64'h7, 64'hFFFFFFFE, 0);
        add_vec(0, 4'h2, 64'h80000000, 64'h24, 64'hF8000000, 0);
        add_vec(0, 4'h1, 64'h80000000, 64'h24, 64'h08000000, 0);
        add_vec(0, 4'hA, 64'h1234, 64'h0, 64'h12340000, 0);
        add_vec(0, 4'h0, 64'h1, 64'h1F, 64'h80000000, 0);
        add_vec(0, 4'h5, 64'hF0F0F0F0, 64'hFF00FF00, 64'hF000F000, 0);
        add_vec(0, 4'h8, 64'h0, 64'h0, 64'hFFFFFFFF, 0);
        add_vec(0, 4'h9, 64'h5, 64'h3, 64'h0, 0);
        add_vec(0, 4'hF, 64'h1234, 64'h5678, 64'h0, 0);
        add_vec(0, 4'hB, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h1, 32);
        add_vec(0, 4'hC, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 32);
        add_vec(0, 4'hD, 64'd100, 64'd7, 64'd14, 32);
        add_vec(0, 4'hE, 64'd100, 64'd7, 64'd2, 32);
        add_vec(0, 4'hD, 64'h12345678, 64'h0, 64'hFFFFFFFF, 32);
        add_vec(0, 4'hE, 64'd9, 64'h0, 64'd9, 32);
        add_vec(1, 4'h3, 64'hFFFF, 64'h1, 64'h0, 0);
        add_vec(1, 4'h2, 64'h8000, 64'h14, 64'hF800, 0);
        add_vec(1, 4'hA, 64'h12, 64'h0, 64'h1200, 0);
        add_vec(1, 4'hB, 64'hFFFF, 64'hFFFF, 64'h1, 16);
        add_vec(1, 4'hC, 64'hFFFF, 64'hFFFF, 64'hFFFE, 16);
        add_vec(1, 4'hD, 64'd1000, 64'd10, 64'd100, 16);
        add_vec(1, 4'hE, 64'hFFFF, 64'h0, 64'hFFFF, 16);

        foreach (vecs[i]) begin
            run_op(vecs[i].sel, vecs[i].ctrl, vecs[i].a, vecs[i].b, r, z, lt, rs);
            check($sformatf("vec%0d_result", i), r, vecs[i].exp);
            check($sformatf("vec%0d_zero", i), {63'h0, z}, {63'h0, vecs[i].exp == 64'h0});
            check($sformatf("vec%0d_wait", i), 64'(lt), 64'(vecs[i].wait_c));
            check($sformatf("vec%0d_busy_ready", i), {63'h0, rs}, 64'h0);
        end
        tick();

        // Backpressure: held result, no accept while stalled, then same-cycle replace.
        sel_s = 1'b0; out_ready_s = 1'b1; in_valid_s = 1'b1; ctrl_s = 4'h3; op1_s = 64'd1; op2_s = 64'd2;
        #1;
        check("bp_first_ready", {63'h0, cur_in_ready}, 64'h1);
        tick();
        out_ready_s = 1'b0; op1_s = 64'd10; op2_s = 64'd20;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {63'h0, cur_out_valid}, 64'h1);
            check("bp_hold", cur_result, 64'd3);
            check("bp_ready_low", {63'h0, cur_in_ready}, 64'h0);
            tick();
        end
        out_ready_s = 1'b1;
        #1;
        check("bp_release_ready", {63'h0, cur_in_ready}, 64'h1);
        tick();
        check("bp_replace", cur_result, 64'd30);
        check("bp_replace_valid", {63'h0, cur_out_valid}, 64'h1);
        op1_s = 64'd4; op2_s = 64'd4;
        tick();
        check("b2b_result", cur_result, 64'd8);
        in_valid_s = 1'b0;
        tick();
        check("drain_valid", {63'h0, cur_out_valid}, 64'h0);

        // Reset in the middle of a divide discards it.
        in_valid_s = 1'b1; ctrl_s = 4'hD; op1_s = 64'd100; op2_s = 64'd7;
        #1;
        tick();
        in_valid_s = 1'b0;
        repeat (10) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        check("mid_rst_valid", {63'h0, cur_out_valid}, 64'h0);
        check("mid_rst_result", cur_result, 64'h0);
        check("mid_rst_zero", {63'h0, cur_zero}, 64'h1);
        check("mid_rst_ready", {63'h0, cur_in_ready}, 64'h1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (cur_out_valid) seen++;
            tick();
        end
        check("mid_rst_no_stale", 64'(seen), 64'h0);
        run_op(1'b0, 4'h9, 64'd3, 64'd5, r, z, lt, rs);
        check("post_rst_slt", r, 64'd1);

        // Random operations against the reference model.
        for (int i = 0; i < 160; i++) begin
            bit s;
            int w;
            logic [3:0] c;
            longint unsigned a, b, e;
            s = 1'($urandom);
            w = s ? 16 : 32;
            c = 4'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = 64'd0;
                1: b = 64'($urandom_range(1, 20));
                default: ;
            endcase
            e = model(w, c, a, b);
            run_op(s, c, a, b, r, z, lt, rs);
            check("rand_result", r, e);
            check("rand_zero", {63'h0, z}, {63'h0, e == 64'h0});
            check("rand_wait", 64'(lt), ((c >= 4'hB) && (c <= 4'hE)) ? 64'(w) : 64'h0);
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
